sync_fifo_flags: RTL and testbench

Parametrised single-clock FIFO, successor to the dual-clock FIFO. Adds selectable first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. Intended for same-domain buffering between pipeline stages and as the drop-in buffer wherever no clock crossing exists.

---
 rtl/sync_fifo_flags_if.sv | 28 ++
 rtl/sync_fifo_flags.sv | 81 ++++++++
 tb/tb_sync_fifo_flags.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_flags_if.sv
// Write/read handshake, status flags and sticky errors of sync_fifo_flags.
interface sync_fifo_flags_if #(
  parameter int Addr_width = 5,
  parameter int Data_width = 8
);
  logic                  Wr_enable;
  logic [Data_width-1:0] data_in;
  logic                  Read_enable;
  logic [Data_width-1:0] data_out;
  logic                  err_clr;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [Addr_width:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output Wr_enable, data_in, Read_enable, err_clr,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  Wr_enable, data_in, Read_enable, err_clr,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with optional FWFT, almost flags, count and sticky errors; flags 1 cycle after the edge.
// No backpressure beyond full/empty: writes while full and reads while empty are dropped and flagged.
module sync_fifo_flags #(
  parameter int Addr_width = 5,
  parameter int Data_width = 8,
  parameter int FWFT       = 0,
  parameter int AF_level   = 28,
  parameter int AE_level   = 4
) (
  input  logic               clk,
  input  logic               rst,
  sync_fifo_flags_if.slave   bus
);
  localparam int DEPTH = 1 << Addr_width;
  localparam logic [Addr_width:0] DEPTH_C = {1'b1, {Addr_width{1'b0}}};
  localparam logic [Addr_width:0] AF_C    = (Addr_width+1)'(AF_level);
  localparam logic [Addr_width:0] AE_C    = (Addr_width+1)'(AE_level);

  logic [Data_width-1:0] mem [DEPTH];
  logic [Addr_width:0]   wr_ptr, rd_ptr, cnt, cnt_nxt;
  logic                  full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
  logic [Data_width-1:0] dout_q, head_dat;
  logic                  wr_acc, rd_acc;

  assign wr_acc   = bus.Wr_enable   & ~full_q;
  assign rd_acc   = bus.Read_enable & ~empty_q;
  assign head_dat = mem[rd_ptr[Addr_width-1:0]];

  always_comb begin
    cnt_nxt = cnt;
    if (wr_acc && !rd_acc)
      cnt_nxt = cnt + 1'b1;
    else if (rd_acc && !wr_acc)
      cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr[Addr_width-1:0]] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout_q <= head_dat;
      end
      cnt     <= cnt_nxt;
      // Flags come from the next count so they line up with the count register.
      full_q  <= (cnt_nxt == DEPTH_C);
      empty_q <= (cnt_nxt == '0);
      af_q    <= (cnt_nxt >= AF_C);
      ae_q    <= (cnt_nxt <= AE_C);
      // A new error on the same edge as err_clr must survive the clear.
      ovf_q   <= (bus.Wr_enable   & full_q)  | (ovf_q & ~bus.err_clr);
      unf_q   <= (bus.Read_enable & empty_q) | (unf_q & ~bus.err_clr);
    end
  end

  assign bus.data_out     = (FWFT != 0) ? (empty_q ? '0 : head_dat) : dout_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = cnt;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives a standard-mode and an FWFT instance with identical stimulus and compares both to a queue model.
module tb_sync_fifo_flags;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int DEPTH = 32;
  localparam int AF = 28;
  localparam int AE = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_flags_if #(.Addr_width(AW), .Data_width(DW)) i0 ();
  sync_fifo_flags_if #(.Addr_width(AW), .Data_width(DW)) i1 ();

  sync_fifo_flags #(.Addr_width(AW), .Data_width(DW), .FWFT(0), .AF_level(AF), .AE_level(AE))
    u_std (.clk(clk), .rst(rst), .bus(i0.slave));
  sync_fifo_flags #(.Addr_width(AW), .Data_width(DW), .FWFT(1), .AF_level(AF), .AE_level(AE))
    u_fwft (.clk(clk), .rst(rst), .bus(i1.slave));

  // Reference state: contents as a queue, registered standard-mode output, sticky errors.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_ovf, m_unf;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [DW-1:0] d, input logic re, input logic clr);
    i0.Wr_enable = we; i0.data_in = d; i0.Read_enable = re; i0.err_clr = clr;
    i1.Wr_enable = we; i1.data_in = d; i1.Read_enable = re; i1.err_clr = clr;
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check("count",  32'(i0.count), 32'(n));
    check("full",   32'(i0.full), 32'(n == DEPTH));
    check("empty",  32'(i0.empty), 32'(n == 0));
    check("afull",  32'(i0.almost_full), 32'(n >= AF));
    check("aempty", 32'(i0.almost_empty), 32'(n <= AE));
    check("ovf",    32'(i0.overflow), 32'(m_ovf));
    check("unf",    32'(i0.underflow), 32'(m_unf));
    check("dout_std",  32'(i0.data_out), 32'(m_dout));
    check("dout_fwft", 32'(i1.data_out), (n == 0) ? 32'd0 : 32'(q[0]));
    check("count_fwft", 32'(i1.count), 32'(n));
  endtask

  task automatic step(input logic we, input logic [DW-1:0] d, input logic re, input logic clr);
    logic was_full, was_empty;
    drive(we, d, re, clr);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (re && !was_empty) m_dout = q.pop_front();
    if (we && !was_full) q.push_back(d);
    m_ovf = (we && was_full)  || (m_ovf && !clr);
    m_unf = (re && was_empty) || (m_unf && !clr);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] w;
    model_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;

    // Fill 0x01..0x20, then one write too many.
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0);
      if (i == AF - 1) check("afull_below", 32'(i0.almost_full), 32'd0);
      if (i == AF)     check("afull_at",    32'(i0.almost_full), 32'd1);
    end
    check("full_32", 32'(i0.full), 32'd1);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    check("ovf_extra", 32'(i0.overflow), 32'd1);
    check("cnt_extra", 32'(i0.count), 32'd32);
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      check("drain_order", 32'(i0.data_out), 32'(i));
    end
    step(1'b0, '0, 1'b0, 1'b1);

    // FWFT: a write into empty shows up the next cycle; one pop empties it.
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    check("fwft_a5", 32'(i1.data_out), 32'hA5);
    check("fwft_nempty", 32'(i1.empty), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("fwft_zero", 32'(i1.data_out), 32'd0);
    check("fwft_empty", 32'(i1.empty), 32'd1);

    // Simultaneous read/write while full.
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    check("rw_full_cnt", 32'(i0.count), 32'd31);
    check("rw_full_ovf", 32'(i0.overflow), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("ovf_clr", 32'(i0.overflow), 32'd0);

    // Hold occupancy at 10 across several pointer wraps.
    while (q.size() > 10) step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b1, DW'($urandom), 1'b1, 1'b0);
    check("steady_cnt", 32'(i0.count), 32'd10);

    // Underflow set beats a same-edge clear.
    while (q.size() > 0) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    check("unf_setwins", 32'(i0.underflow), 32'd1);
    step(1'b1, 8'h3C, 1'b1, 1'b0);
    check("rw_empty_cnt", 32'(i0.count), 32'd1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      w = DW'($urandom);
      step(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0);
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) == 0), DW'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0);

    // Asynchronous reset in the middle of a fill.
    while (q.size() > 0) step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    check("pre_rst_cnt", 32'(i0.count), 32'd15);
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("arst_cnt", 32'(i0.count), 32'd0);
    check("arst_empty", 32'(i0.empty), 32'd1);
    check("arst_fwft", 32'(i1.data_out), 32'd0);
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    step(1'b1, 8'h42, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("post_rst_dat", 32'(i0.data_out), 32'h42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
